output_vc_arbiter: RTL

- Downstream end of the per-port flit request/response interface that each router input datapath drives toward the output side.
- Merges flits from N_INPUTS input datapaths onto one router output link.
- Uses round-robin arbitration and keeps per-virtual-channel wormhole locks, so head-to-tail packets are never interleaved within one VC.
- Instanced once per router output direction; its output feeds the link toward the neighbour router or the local NI.

---
 rtl/output_vc_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/output_vc_arbiter.sv
// Flit types and request/response structs shared by the router datapaths,
// followed by the per-output round-robin arbiter with per-VC wormhole locks.
package ravenoc_pkg;
  localparam int FLIT_WIDTH = 34;
  localparam int N_VIRT_CHN = 2;
  localparam int VC_WIDTH   = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] fdata;
    logic                  valid;
    logic [VC_WIDTH-1:0]   vc_id;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;
endpackage

// Merges N_INPUTS flit streams onto one output link. HEAD flits claim a VC,
// TAIL flits release it, so a packet is never interleaved with another packet
// on the same VC. A stalled grant is pinned until it handshakes so the output
// stays stable under backpressure.
module output_vc_arbiter
  import ravenoc_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int N_VIRT_CHN = ravenoc_pkg::N_VIRT_CHN,
  parameter int FLIT_WIDTH = ravenoc_pkg::FLIT_WIDTH
) (
  input  logic         clk,
  input  logic         arst,
  input  s_flit_req_t  fin_req_i  [N_INPUTS],
  output s_flit_resp_t fin_resp_o [N_INPUTS],
  output s_flit_req_t  fout_req_o,
  input  s_flit_resp_t fout_resp_i,
  output logic [N_VIRT_CHN-1:0] vc_lock_o
);

  localparam int IDX_W = $clog2(N_INPUTS);

  logic [N_VIRT_CHN-1:0] lock_vld;
  logic [IDX_W-1:0]      owner [N_VIRT_CHN];
  logic [IDX_W-1:0]      rr_ptr;
  logic                  hold_vld;
  logic [IDX_W-1:0]      hold_idx;

  logic [N_INPUTS-1:0]   elig;
  logic [IDX_W-1:0]      grant;
  logic                  gnt_vld;
  logic                  handshake;
  flit_type_t            out_type;

  // Per-input eligibility: HEADs need a free VC, BODY/TAIL need to own it.
  always_comb begin
    flit_type_t          ftype;
    logic [VC_WIDTH-1:0] vc;
    elig  = '0;
    ftype = HEAD;
    vc    = '0;
    for (int p = 0; p < N_INPUTS; p++) begin
      ftype = flit_type_t'(fin_req_i[p].fdata[FLIT_WIDTH-1 -: 2]);
      vc    = fin_req_i[p].vc_id;
      if (fin_req_i[p].valid) begin
        if (ftype == HEAD || ftype == HEAD_TAIL)
          elig[p] = !lock_vld[vc];
        else
          elig[p] = lock_vld[vc] && (owner[vc] == IDX_W'(p));
      end
    end
  end

  // Round-robin pick starting after the last granted input, unless a
  // backpressured grant is being held.
  always_comb begin
    int idx;
    grant   = hold_idx;
    gnt_vld = hold_vld;
    idx     = 0;
    if (!hold_vld) begin
      for (int off = 1; off <= N_INPUTS; off++) begin
        idx = (int'(rr_ptr) + off) % N_INPUTS;
        if (!gnt_vld && elig[idx]) begin
          gnt_vld = 1'b1;
          grant   = IDX_W'(idx);
        end
      end
    end
  end

  // Zero-latency mux of the granted request; only the winner sees ready.
  always_comb begin
    fout_req_o = '0;
    for (int p = 0; p < N_INPUTS; p++)
      fin_resp_o[p] = '0;
    if (gnt_vld) begin
      fout_req_o              = fin_req_i[grant];
      fin_resp_o[grant].ready = fout_resp_i.ready;
    end
  end

  assign handshake = fout_req_o.valid && fout_resp_i.ready;
  assign out_type  = flit_type_t'(fout_req_o.fdata[FLIT_WIDTH-1 -: 2]);
  assign vc_lock_o = lock_vld;

  // Hold, round-robin pointer and VC lock updates on each accepted flit.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      lock_vld <= '0;
      for (int v = 0; v < N_VIRT_CHN; v++)
        owner[v] <= '0;
      rr_ptr   <= IDX_W'(N_INPUTS - 1);
      hold_vld <= 1'b0;
      hold_idx <= '0;
    end else begin
      if (fout_req_o.valid && !fout_resp_i.ready) begin
        hold_vld <= 1'b1;
        hold_idx <= grant;
      end else if (handshake) begin
        hold_vld <= 1'b0;
      end
      if (handshake) begin
        rr_ptr <= grant;
        if (out_type == HEAD) begin
          lock_vld[fout_req_o.vc_id] <= 1'b1;
          owner[fout_req_o.vc_id]    <= grant;
        end else if (out_type == TAIL) begin
          lock_vld[fout_req_o.vc_id] <= 1'b0;
        end
      end
    end
  end

endmodule
